stage_3_ex: RTL and testbench
=============================

// Module: stage_3_EX
// PURPOSE
//  Execute stage of the 5-stage pipeline, between ID and MEM. Registers the ID bundle, computes the ALU result and
//  issues the data-SRAM request for ld.w/st.w.
//  Holds a load/store until the SRAM accepts the address. Drives the EX write-back address for ID hazard detection.
// PARAMETERS
//  (none; bundle widths fixed: ID->EX 117 bits, EX->MEM 71 bits)
// PORTS
//  clk                 in   1    clock; single clock domain
//  reset               in   1    synchronous, active-high reset
//  valid_2             in   1    ID holds a valid instruction
//  allow_3             out  1    EX can accept from ID this cycle
//  valid_3             out  1    EX holds a valid instruction
//  allow_4             in   1    MEM can accept from EX
//  stage_2_to_3        in   117  {rf_we,dest[4:0],res_from_mem,alu_src1[31:0],alu_src2[31:0],alu_op[11:0],mem_we,mem_en,pc[31:0]}
//  memory_write_data   in   32   store data from ID, captured with the bundle
//  stage_3_to_4        out  71   {rf_we,dest[4:0],res_from_mem,alu_result[31:0],pc[31:0]}
//  rf_waddr_3_fwd      out  5    dest when valid_3&rf_we, else 5'd0
//  data_sram_req       out  1    data request
//  data_sram_we        out  4    byte write enables (4'hf store, 4'h0 load)
//  data_sram_addr      out  32   alu_result
//  data_sram_wdata     out  32   registered memory_write_data
//  data_sram_addr_ok   in   1    request accepted this cycle
// BEHAVIOUR
//  - Reset: valid_3=0, all bundle/data registers 0, req_done=0. This forces data_sram_req=0 and rf_waddr_3_fwd=0.
//  - allow_3 = ~valid_3 | (readygo_3 & allow_4). When allow_3, load valid_3<=valid_2.
//    Bundle and wdata registers load only when allow_3 & valid_2.
//  - ALU is combinational from the registered bundle. alu_op is one-hot:
//    [0]add [1]sub [2]slt(signed) [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui(=src2).
//    Shifts use src2[4:0]. Add/sub wrap mod 2^32. alu_op=0 gives result 0.
//  - Request FSM, states IDLE/DONE, tracked by req_done:
//    - data_sram_req = valid_3 & mem_en & ~req_done.
//    - IDLE->DONE on req & addr_ok & ~allow_4. DONE->IDLE when the stage advances (valid_3 & readygo_3 & allow_4).
//    - If addr_ok and allow_4 arrive in the same cycle, the stage advances directly and stays IDLE.
//  - readygo_3 = ~mem_en | req_done | (data_sram_req & data_sram_addr_ok).
//    Non-memory instructions take 1 cycle. A memory op stalls until addr_ok is seen, exactly one request is issued,
//    and the request is never reissued while MEM back-pressures.
//  - Request fields (addr, we, wdata) stay stable while req=1 and addr_ok=0.
//  - Bubble (valid_3=0): no request, fwd addr 0, stage_3_to_4 contents don't-care.
//  - Reset asserted mid-request drops the request in the next cycle. In-flight SRAM state is not tracked here.
// CONFIGURATION
//  EX_DATA_FWD_EN defined: adds outputs rf_wdata_3_fwd[31:0] (=alu_result) and rf_is_load_3_fwd (=valid_3&res_from_mem).
//  These let ID bypass EX results and detect load-use.
//  Undefined: both ports are absent. ID relies on address-only hazard info.
// STRUCTURE
//  Shared package/header: bundle widths (117, 71), ALU_OP_* bit indices, data_sram_we encodings.
//  One sub-module: alu (alu_op, src1, src2 -> result), purely combinational. The FSM and pipeline register stay in the stage.
// TESTING
//  1. add: src1=5, src2=7, op[0], allow_4=1 -> next cycle alu_result=12, valid_3=1, allow_3=1, data_sram_req=0.
//  2. st.w: addr 0x1000_0004, wdata 0xDEADBEEF, addr_ok held low 3 cycles -> req=1 and allow_3=0 for 3 cycles.
//     When addr_ok=1: we=4'hf, exactly one accepted request, advances same cycle.
//  3. ld.w with addr_ok=1 and allow_4=0 for 2 cycles -> req low after acceptance, valid_3 held, no second request.
//     Advances when allow_4=1.
//  4. slt src1=0xFFFFFFFF, src2=1 -> 1; sltu same -> 0; sra 0x80000000 by 4 -> 0xF8000000.
//  5. rf_we=1, dest=5 -> rf_waddr_3_fwd=5; same with valid_3=0 or rf_we=0 -> 0.
//  6. Reset asserted while req=1 and addr_ok=0 -> next cycle req=0, valid_3=0, fwd addr 0.

Source files
------------

// File: rtl/stage_3_ex_pkg.sv
// Shared definitions for the EX stage: bundle layouts, ALU op bit indices,
// data-SRAM write-enable encodings and the request FSM state type.
package stage_3_ex_pkg;

  localparam int unsigned ID_EX_W  = 117;
  localparam int unsigned EX_MEM_W = 71;
  localparam int unsigned ALU_OP_W = 12;

  // One-hot ALU operation bit positions within alu_op
  localparam int unsigned ALU_OP_ADD  = 0;
  localparam int unsigned ALU_OP_SUB  = 1;
  localparam int unsigned ALU_OP_SLT  = 2;
  localparam int unsigned ALU_OP_SLTU = 3;
  localparam int unsigned ALU_OP_AND  = 4;
  localparam int unsigned ALU_OP_NOR  = 5;
  localparam int unsigned ALU_OP_OR   = 6;
  localparam int unsigned ALU_OP_XOR  = 7;
  localparam int unsigned ALU_OP_SLL  = 8;
  localparam int unsigned ALU_OP_SRL  = 9;
  localparam int unsigned ALU_OP_SRA  = 10;
  localparam int unsigned ALU_OP_LUI  = 11;

  localparam logic [3:0] SRAM_WE_STORE = 4'hf;
  localparam logic [3:0] SRAM_WE_LOAD  = 4'h0;

  typedef struct packed {
    logic                rf_we;
    logic [4:0]          dest;
    logic                res_from_mem;
    logic [31:0]         alu_src1;
    logic [31:0]         alu_src2;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_we;
    logic                mem_en;
    logic [31:0]         pc;
  } id_ex_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_mem_t;

  typedef enum logic {
    REQ_IDLE,
    REQ_DONE
  } req_state_e;

endpackage

// File: rtl/stage_3_ex_alu.sv
// Combinational ALU for the EX stage; alu_op is one-hot, an all-zero op yields 0.
module stage_3_ex_alu
  import stage_3_ex_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
  output logic [31:0]         alu_result
);

  logic [4:0]  shamt;
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] sra_res;
  logic        slt_res;
  logic        sltu_res;

  assign shamt    = alu_src2[4:0];
  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_res = alu_src1 < alu_src2;
  // Kept in its own assignment so the shift stays arithmetic (signed context)
  assign sra_res  = $signed(alu_src1) >>> shamt;

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_OP_ADD])  alu_result = alu_result | add_res;
    if (alu_op[ALU_OP_SUB])  alu_result = alu_result | sub_res;
    if (alu_op[ALU_OP_SLT])  alu_result = alu_result | {31'd0, slt_res};
    if (alu_op[ALU_OP_SLTU]) alu_result = alu_result | {31'd0, sltu_res};
    if (alu_op[ALU_OP_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_OP_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OP_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_OP_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_OP_SLL])  alu_result = alu_result | (alu_src1 << shamt);
    if (alu_op[ALU_OP_SRL])  alu_result = alu_result | (alu_src1 >> shamt);
    if (alu_op[ALU_OP_SRA])  alu_result = alu_result | sra_res;
    if (alu_op[ALU_OP_LUI])  alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/stage_3_ex.sv
// EX pipeline stage: registers the ID bundle, runs the ALU and issues one data-SRAM
// request per ld.w/st.w. Define EX_DATA_FWD_EN to expose EX result/load-use bypass outputs.
module stage_3_ex
  import stage_3_ex_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_2,
  output logic                allow_3,
  output logic                valid_3,
  input  logic                allow_4,
  input  logic [ID_EX_W-1:0]  stage_2_to_3,
  input  logic [31:0]         memory_write_data,
  output logic [EX_MEM_W-1:0] stage_3_to_4,
  output logic [4:0]          rf_waddr_3_fwd,
`ifdef EX_DATA_FWD_EN
  output logic [31:0]         rf_wdata_3_fwd,
  output logic                rf_is_load_3_fwd,
`endif
  output logic                data_sram_req,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  input  logic                data_sram_addr_ok
);

  id_ex_t      bundle_q;
  ex_mem_t     out_bundle;
  logic [31:0] wdata_q;
  logic [31:0] alu_result;
  req_state_e  state_q;
  req_state_e  state_d;
  logic        req_done;
  logic        readygo_3;
  logic        advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_3  <= 1'b0;
      bundle_q <= '0;
      wdata_q  <= '0;
    end else begin
      if (allow_3) valid_3 <= valid_2;
      if (allow_3 && valid_2) begin
        bundle_q <= id_ex_t'(stage_2_to_3);
        wdata_q  <= memory_write_data;
      end
    end
  end

  stage_3_ex_alu u_alu (
    .alu_op     (bundle_q.alu_op),
    .alu_src1   (bundle_q.alu_src1),
    .alu_src2   (bundle_q.alu_src2),
    .alu_result (alu_result)
  );

  // DONE remembers an accepted request while MEM back-pressures, so it is never reissued
  always_ff @(posedge clk) begin
    if (reset) state_q <= REQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE: if (data_sram_req && data_sram_addr_ok && !allow_4) state_d = REQ_DONE;
      REQ_DONE: if (advance) state_d = REQ_IDLE;
      default:  state_d = REQ_IDLE;
    endcase
  end

  assign req_done  = (state_q == REQ_DONE);
  assign readygo_3 = ~bundle_q.mem_en | req_done | (data_sram_req & data_sram_addr_ok);
  assign advance   = valid_3 & readygo_3 & allow_4;
  assign allow_3   = ~valid_3 | (readygo_3 & allow_4);

  assign data_sram_req   = valid_3 & bundle_q.mem_en & ~req_done;
  assign data_sram_we    = bundle_q.mem_we ? SRAM_WE_STORE : SRAM_WE_LOAD;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = wdata_q;

  assign rf_waddr_3_fwd = (valid_3 && bundle_q.rf_we) ? bundle_q.dest : 5'd0;

`ifdef EX_DATA_FWD_EN
  assign rf_wdata_3_fwd   = alu_result;
  assign rf_is_load_3_fwd = valid_3 & bundle_q.res_from_mem;
`endif

  always_comb begin
    out_bundle.rf_we        = bundle_q.rf_we;
    out_bundle.dest         = bundle_q.dest;
    out_bundle.res_from_mem = bundle_q.res_from_mem;
    out_bundle.alu_result   = alu_result;
    out_bundle.pc           = bundle_q.pc;
  end

  assign stage_3_to_4 = out_bundle;

endmodule

// File: tb/tb_stage_3_ex.sv
// Scoreboard bench for stage_3_ex: directed cases plus a randomized back-pressure run.
module tb_stage_3_ex;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_2;
  logic         allow_3;
  logic         valid_3;
  logic         allow_4;
  logic [116:0] stage_2_to_3;
  logic [31:0]  memory_write_data;
  logic [70:0]  stage_3_to_4;
  logic [4:0]   rf_waddr_3_fwd;
  logic         data_sram_req;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
`ifdef EX_DATA_FWD_EN
  logic [31:0]  rf_wdata_3_fwd;
  logic         rf_is_load_3_fwd;
`endif

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  typedef struct {
    logic [70:0] out;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   req_cnt  = 0;
  bit   rand_done;

  stage_3_ex dut (
    .clk               (clk),
    .reset             (reset),
    .valid_2           (valid_2),
    .allow_3           (allow_3),
    .valid_3           (valid_3),
    .allow_4           (allow_4),
    .stage_2_to_3      (stage_2_to_3),
    .memory_write_data (memory_write_data),
    .stage_3_to_4      (stage_3_to_4),
    .rf_waddr_3_fwd    (rf_waddr_3_fwd),
`ifdef EX_DATA_FWD_EN
    .rf_wdata_3_fwd    (rf_wdata_3_fwd),
    .rf_is_load_3_fwd  (rf_is_load_3_fwd),
`endif
    .data_sram_req     (data_sram_req),
    .data_sram_we      (data_sram_we),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] t;
    r = 32'd0;
    for (int i = 0; i < 12; i++) begin
      if (op[i]) begin
        case (i)
          0:  r = r | (a + b);
          1:  r = r | (a - b);
          2:  r = r | (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          3:  r = r | ((a < b) ? 32'd1 : 32'd0);
          4:  r = r | (a & b);
          5:  r = r | ~(a | b);
          6:  r = r | (a | b);
          7:  r = r | (a ^ b);
          8:  r = r | (a << b[4:0]);
          9:  r = r | (a >> b[4:0]);
          10: begin t = $signed(a) >>> b[4:0]; r = r | t; end
          default: r = r | b;
        endcase
      end
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 with the instruction latched into EX.
  task automatic issue(input logic rf_we, input logic [4:0] dest, input logic rfm,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] op,
                       input logic mwe, input logic men, input logic [31:0] pc,
                       input logic [31:0] wd);
    exp_t e;
    bit   ok;
    int   n;
    stage_2_to_3      = {rf_we, dest, rfm, s1, s2, op, mwe, men, pc};
    memory_write_data = wd;
    valid_2           = 1'b1;
    e.out    = {rf_we, dest, rfm, alu_ref(op, s1, s2), pc};
    e.mem_en = men;
    e.mem_we = mwe;
    e.wdata  = wd;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (allow_3 === 1'b1) ok = 1'b1;
      n++;
    end
    @(posedge clk);
    #1;
    valid_2 = 1'b0;
    if (ok) sb.push_back(e);
    else check("issue_timeout", 72'(0), 72'(1));
  endtask

  task automatic run_alu(input string tag, input logic [11:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(1'b1, 5'd9, 1'b0, a, b, op, 1'b0, 1'b0, 32'h200, 32'h0);
    @(negedge clk);
    check(tag, 72'(stage_3_to_4[63:32]), 72'(exp));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: checks forwarding, request fields and the EX->MEM transfer
  always @(negedge clk) begin
    if (!reset) begin
      check("valid_3", 72'(valid_3), 72'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("fwd_addr", 72'(rf_waddr_3_fwd), 72'(sb[0].out[70] ? sb[0].out[69:65] : 5'd0));
        check("req", 72'(data_sram_req), 72'(sb[0].mem_en && req_cnt == 0));
`ifdef EX_DATA_FWD_EN
        check("fwd_wdata", 72'(rf_wdata_3_fwd), 72'(sb[0].out[63:32]));
        check("fwd_is_load", 72'(rf_is_load_3_fwd), 72'(sb[0].out[64]));
`endif
        if (data_sram_req) begin
          check("req_addr", 72'(data_sram_addr), 72'(sb[0].out[63:32]));
          check("req_we", 72'(data_sram_we), 72'(sb[0].mem_we ? 4'hf : 4'h0));
          check("req_wdata", 72'(data_sram_wdata), 72'(sb[0].wdata));
        end
        if (data_sram_req && data_sram_addr_ok) req_cnt++;
        if (allow_3) begin
          check("ex_to_mem", 72'(stage_3_to_4), 72'(sb[0].out));
          check("req_count", 72'(req_cnt), 72'(sb[0].mem_en ? 1 : 0));
          req_cnt = 0;
          void'(sb.pop_front());
        end
      end else begin
        check("bubble_req", 72'(data_sram_req), 72'(0));
        check("bubble_fwd", 72'(rf_waddr_3_fwd), 72'(0));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset             = 1'b1;
    valid_2           = 1'b0;
    allow_4           = 1'b1;
    data_sram_addr_ok = 1'b0;
    stage_2_to_3      = '0;
    memory_write_data = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_valid_3", 72'(valid_3), 72'(0));
    check("rst_req", 72'(data_sram_req), 72'(0));
    check("rst_fwd", 72'(rf_waddr_3_fwd), 72'(0));
    check("rst_allow_3", 72'(allow_3), 72'(1));
    check("rst_bundle", 72'(stage_3_to_4), 72'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // add 5+7
    issue(1'b1, 5'd1, 1'b0, 32'd5, 32'd7, OP_ADD, 1'b0, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check("add_result", 72'(stage_3_to_4[63:32]), 72'(12));
    check("add_valid_3", 72'(valid_3), 72'(1));
    check("add_allow_3", 72'(allow_3), 72'(1));
    check("add_req", 72'(data_sram_req), 72'(0));
    @(posedge clk);
    #1;

    // st.w with addr_ok low for 3 cycles
    issue(1'b0, 5'd0, 1'b0, 32'h1000_0000, 32'd4, OP_ADD, 1'b1, 1'b1, 32'h104, 32'hDEADBEEF);
    repeat (3) begin
      @(negedge clk);
      check("st_wait_req", 72'(data_sram_req), 72'(1));
      check("st_wait_allow_3", 72'(allow_3), 72'(0));
      check("st_wait_addr", 72'(data_sram_addr), 72'(32'h1000_0004));
      @(posedge clk);
    end
    #1;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    check("st_req", 72'(data_sram_req), 72'(1));
    check("st_we", 72'(data_sram_we), 72'(4'hf));
    check("st_wdata", 72'(data_sram_wdata), 72'(32'hDEADBEEF));
    check("st_allow_3", 72'(allow_3), 72'(1));
    @(posedge clk);
    #1;
    data_sram_addr_ok = 1'b0;

    // ld.w accepted while MEM back-pressures for 2 cycles
    allow_4           = 1'b0;
    data_sram_addr_ok = 1'b1;
    issue(1'b1, 5'd3, 1'b1, 32'h2000_0000, 32'd8, OP_ADD, 1'b0, 1'b1, 32'h108, 32'h0);
    @(negedge clk);
    check("ld_req", 72'(data_sram_req), 72'(1));
    check("ld_we", 72'(data_sram_we), 72'(4'h0));
    check("ld_allow_3", 72'(allow_3), 72'(0));
    @(posedge clk);
    @(negedge clk);
    check("ld_held_req", 72'(data_sram_req), 72'(0));
    check("ld_held_valid", 72'(valid_3), 72'(1));
    check("ld_held_allow_3", 72'(allow_3), 72'(0));
    @(posedge clk);
    #1;
    allow_4 = 1'b1;
    @(negedge clk);
    check("ld_go_req", 72'(data_sram_req), 72'(0));
    check("ld_go_allow_3", 72'(allow_3), 72'(1));
    @(posedge clk);
    #1;
    data_sram_addr_ok = 1'b0;

    // Compare and shift corner cases
    run_alu("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_alu("sltu_neg", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_alu("sra_sign", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_alu("lui", OP_LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
    run_alu("op_zero", 12'h000, 32'h1234_5678, 32'h1, 32'h0);
    run_alu("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);

    // Forwarded write-back address
    allow_4 = 1'b0;
    issue(1'b1, 5'd5, 1'b0, 32'd1, 32'd1, OP_ADD, 1'b0, 1'b0, 32'h10C, 32'h0);
    @(negedge clk);
    check("fwd_rf_we", 72'(rf_waddr_3_fwd), 72'(5));
    @(posedge clk);
    #1;
    allow_4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("fwd_bubble", 72'(rf_waddr_3_fwd), 72'(0));
    @(posedge clk);
    #1;
    issue(1'b0, 5'd5, 1'b0, 32'd1, 32'd1, OP_ADD, 1'b0, 1'b0, 32'h110, 32'h0);
    @(negedge clk);
    check("fwd_no_we", 72'(rf_waddr_3_fwd), 72'(0));
    @(posedge clk);
    #1;

    // Reset during a pending request
    issue(1'b1, 5'd7, 1'b0, 32'h3000_0000, 32'd0, OP_ADD, 1'b1, 1'b1, 32'h114, 32'h55AA);
    @(negedge clk);
    check("mid_req", 72'(data_sram_req), 72'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req", 72'(data_sram_req), 72'(0));
    check("mid_rst_valid", 72'(valid_3), 72'(0));
    check("mid_rst_fwd", 72'(rf_waddr_3_fwd), 72'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    req_cnt = 0;

    // Random traffic under random back-pressure and address acceptance
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          logic [11:0] op;
          int unsigned idx;
          logic        men;
          idx = $urandom_range(0, 12);
          op  = (idx == 12) ? 12'h000 : (12'h001 << idx);
          men = ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          issue(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
                $urandom, $urandom, op, 1'($urandom_range(0, 1)), men, $urandom, $urandom);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          allow_4           = 1'($urandom_range(0, 1));
          data_sram_addr_ok = ($urandom_range(0, 2) != 0);
        end
      end
    join

    allow_4           = 1'b1;
    data_sram_addr_ok = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    check("drain_empty", 72'(sb.size()), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
